fresh_rand_source: RTL and testbench

- Producer end of the 96-bit fresh-randomness bus consumed by the masked S-box rotation/reuse logic.
- Holds a 96-bit maximal-length Fibonacci LFSR, seeded through a 32-bit word interface and warmed up before first use.
- Delivers one fresh 96-bit word per accepted valid/ready transfer; consumers derive their rotated copies from this word.

---
 rtl/fresh_rand_source_pkg.sv | 33 +++
 rtl/fresh_rand_source_if.sv | 31 +++
 rtl/fresh_rand_source_lfsr_step_unroll.sv | 27 ++
 rtl/fresh_rand_source.sv | 139 +++++++++++++
 tb/tb_fresh_rand_source.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fresh_rand_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fresh_rand_source_pkg
// Description : Shared widths, LFSR taps, FSM encoding and single-step helper
//               for the fresh-randomness producer.
// Revision    : 1.0 - initial release
// ============================================================================
package fresh_rand_source_pkg;

  localparam int RAND_W         = 96;
  localparam int SEED_W         = 32;
  localparam int NUM_SEED_WORDS = 3;

  // Maximal-length taps for a 96-bit Fibonacci LFSR
  localparam int TAP_A = 95;
  localparam int TAP_B = 93;
  localparam int TAP_C = 48;
  localparam int TAP_D = 46;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } fsm_state_e;

  // One LFSR step: shift left, feedback enters at bit 0
  function automatic logic [RAND_W-1:0] lfsr_step(input logic [RAND_W-1:0] s);
    return {s[RAND_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fresh_rand_source_if.sv
`default_nettype none
// ============================================================================
// Module      : fresh_rand_source_if
// Description : Seed-in / randomness-out handshake bundle. The master side is
//               the randomness producer, the slave side is seeder/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fresh_rand_source_if;
  import fresh_rand_source_pkg::*;

  logic                seed_valid;
  logic                seed_ready;
  logic [SEED_W-1:0]   seed_data;
  logic                rand_valid;
  logic                rand_ready;
  logic [RAND_W-1:0]   rand_out;
  logic                seed_err;
  logic                busy;

  modport master (
    input  seed_valid, seed_data, rand_ready,
    output seed_ready, rand_valid, rand_out, seed_err, busy
  );

  modport slave (
    output seed_valid, seed_data, rand_ready,
    input  seed_ready, rand_valid, rand_out, seed_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/fresh_rand_source_lfsr_step_unroll.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_step_unroll
// Description : Purely combinational chain of STEPS LFSR steps.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step_unroll
  import fresh_rand_source_pkg::*;
#(
  parameter int STEPS = 96
) (
  input  wire logic [RAND_W-1:0] state_in,
  output logic      [RAND_W-1:0] state_out
);

  logic [RAND_W-1:0] chain [0:STEPS];

  assign chain[0] = state_in;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign chain[g+1] = lfsr_step(chain[g]);
  end

  assign state_out = chain[STEPS];

endmodule
`default_nettype wire

// File: rtl/fresh_rand_source.sv
`default_nettype none
// ============================================================================
// Module      : fresh_rand_source
// Description : 96-bit LFSR randomness producer. Seeded by three 32-bit words,
//               warmed up for WARMUP_CYCLES draws, then hands out one fresh
//               word per accepted valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module fresh_rand_source
  import fresh_rand_source_pkg::*;
#(
  parameter int STEPS_PER_DRAW = 96,
  parameter int WARMUP_CYCLES  = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fresh_rand_source_if.master bus
);

  // Value warm_cnt holds during the final warm-up cycle
  localparam logic [7:0] WARM_LAST =
    (WARMUP_CYCLES == 0) ? 8'd0 : 8'(WARMUP_CYCLES - 1);

  fsm_state_e        fsm_q, fsm_d;
  logic [RAND_W-1:0] lfsr_q, lfsr_d;
  logic [1:0]        word_cnt_q, word_cnt_d;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic              seed_err_q, seed_err_d;

  logic [RAND_W-1:0] stepped;
  logic [RAND_W-1:0] seeded;
  logic              seed_ready_w;
  logic              rand_valid_w;
  logic              seed_fire;
  logic              rand_fire;

  // One draw worth of stepping, shared by warm-up and delivery
  lfsr_step_unroll #(
    .STEPS (STEPS_PER_DRAW)
  ) u_unroll (
    .state_in  (lfsr_q),
    .state_out (stepped)
  );

  // Seeds are blocked only while warming so stale state never leaks out
  assign seed_ready_w = (fsm_q != WARM);
  assign rand_valid_w = (fsm_q == RUN);
  assign seed_fire    = bus.seed_valid && seed_ready_w;
  assign rand_fire    = rand_valid_w && bus.rand_ready;

  assign bus.seed_ready = seed_ready_w;
  assign bus.rand_valid = rand_valid_w;
  assign bus.rand_out   = lfsr_q;
  assign bus.seed_err   = seed_err_q;
  assign bus.busy       = (fsm_q == LOAD) || (fsm_q == WARM);

  // Next-state and datapath: seed loading, warm-up stepping, draw on transfer
  always_comb begin
    seeded = lfsr_q;
    case (word_cnt_q)
      2'd0:    seeded[SEED_W-1:0]          = bus.seed_data;
      2'd1:    seeded[2*SEED_W-1:SEED_W]   = bus.seed_data;
      default: seeded[3*SEED_W-1:2*SEED_W] = bus.seed_data;
    endcase

    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    word_cnt_d = word_cnt_q;
    warm_cnt_d = warm_cnt_q;
    seed_err_d = seed_err_q;

    case (fsm_q)
      IDLE: begin
        if (seed_fire) begin
          lfsr_d     = seeded;
          word_cnt_d = 2'd1;
          fsm_d      = LOAD;
        end
      end
      LOAD: begin
        if (seed_fire) begin
          if (word_cnt_q == 2'(NUM_SEED_WORDS - 1)) begin
            word_cnt_d = 2'd0;
            warm_cnt_d = 8'd0;
            // An all-zero LFSR would lock up; substitute the unit state
            if (seeded == '0) begin
              lfsr_d     = {{(RAND_W-1){1'b0}}, 1'b1};
              seed_err_d = 1'b1;
            end else begin
              lfsr_d     = seeded;
              seed_err_d = 1'b0;
            end
            fsm_d = (WARMUP_CYCLES == 0) ? RUN : WARM;
          end else begin
            lfsr_d     = seeded;
            word_cnt_d = word_cnt_q + 2'd1;
          end
        end
      end
      WARM: begin
        lfsr_d     = stepped;
        warm_cnt_d = warm_cnt_q + 8'd1;
        if (warm_cnt_q == WARM_LAST) begin
          fsm_d = RUN;
        end
      end
      RUN: begin
        // A reseed wins over a simultaneous draw; the draw is swallowed
        if (seed_fire) begin
          lfsr_d     = seeded;
          word_cnt_d = 2'd1;
          fsm_d      = LOAD;
        end else if (rand_fire) begin
          lfsr_d = stepped;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      lfsr_q     <= '0;
      word_cnt_q <= 2'd0;
      warm_cnt_q <= 8'd0;
      seed_err_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      word_cnt_q <= word_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fresh_rand_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_fresh_rand_source
// Description : Directed self-checking bench. dut_a runs one step per draw and
//               no warm-up; dut_b runs the default configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fresh_rand_source;

  logic clk = 1'b0;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fresh_rand_source_if ifa ();
  fresh_rand_source_if ifb ();

  fresh_rand_source #(
    .STEPS_PER_DRAW (1),
    .WARMUP_CYCLES  (0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  fresh_rand_source #(
    .STEPS_PER_DRAW (96),
    .WARMUP_CYCLES  (8)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] adv(input logic [95:0] s, input int n);
    logic [95:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = {t[94:0], t[95] ^ t[93] ^ t[48] ^ t[46]};
    return t;
  endfunction

  initial begin
    logic [95:0] exp_a;
    logic [95:0] v;
    logic [95:0] s1;
    s1 = {32'h0F0F_0F0F, 32'h9ABC_DEF0, 32'h1234_5678};

    rst = 1'b1;
    ifa.seed_valid = 1'b0; ifa.seed_data = 32'h0; ifa.rand_ready = 1'b0;
    ifb.seed_valid = 1'b0; ifb.seed_data = 32'h0; ifb.rand_ready = 1'b0;
    tick(); tick();

    // Reset values
    chk ("a_rst_out",   ifa.rand_out,   96'h0);
    chk1("a_rst_sready", ifa.seed_ready, 1'b1);
    chk1("a_rst_rvalid", ifa.rand_valid, 1'b0);
    chk1("a_rst_err",    ifa.seed_err,   1'b0);
    chk1("a_rst_busy",   ifa.busy,       1'b0);
    chk ("b_rst_out",   ifb.rand_out,   96'h0);
    chk1("b_rst_sready", ifb.seed_ready, 1'b1);
    chk1("b_rst_busy",   ifb.busy,       1'b0);
    rst = 1'b0;

    // dut_a: seed 1,0,0 accepted straight out of reset
    ifa.seed_valid = 1'b1; ifa.seed_data = 32'h1;
    tick();
    chk1("a_load_busy",   ifa.busy,       1'b1);
    chk1("a_load_sready", ifa.seed_ready, 1'b1);
    chk1("a_load_rvalid", ifa.rand_valid, 1'b0);
    ifa.seed_data = 32'h0;
    tick();
    tick();
    ifa.seed_valid = 1'b0;
    chk1("a_run_rvalid", ifa.rand_valid, 1'b1);
    chk ("a_run_first",  ifa.rand_out,   96'h1);
    chk1("a_run_busy",   ifa.busy,       1'b0);
    chk1("a_run_err",    ifa.seed_err,   1'b0);

    // 47 back-to-back single-step draws
    ifa.rand_ready = 1'b1;
    exp_a = 96'h1;
    tick();
    chk("a_draw1", ifa.rand_out, 96'h2);
    exp_a = adv(exp_a, 1);
    for (int i = 1; i < 47; i++) begin
      tick();
      exp_a = adv(exp_a, 1);
      chk("a_draw", ifa.rand_out, exp_a);
    end
    chk("a_draw47", ifa.rand_out, 96'h8000_0000_0001);
    ifa.rand_ready = 1'b0;

    // dut_b: all-zero seed
    ifb.seed_valid = 1'b1; ifb.seed_data = 32'h0;
    tick();
    chk1("b_z_busy", ifb.busy, 1'b1);
    tick();
    tick();
    chk1("b_z_err",    ifb.seed_err, 1'b1);
    chk ("b_z_forced", ifb.rand_out, 96'h1);
    // Offer junk seed during warm-up; it must be refused
    ifb.seed_data = 32'hDEAD_BEEF;
    for (int c = 1; c <= 8; c++) begin
      chk1("b_warm_busy",   ifb.busy,       1'b1);
      chk1("b_warm_sready", ifb.seed_ready, 1'b0);
      chk1("b_warm_rvalid", ifb.rand_valid, 1'b0);
      chk1("b_warm_nz",     ifb.rand_out == 96'h0, 1'b0);
      tick();
    end
    ifb.seed_valid = 1'b0;
    chk1("b_lat_rvalid", ifb.rand_valid, 1'b1);
    chk1("b_lat_busy",   ifb.busy,       1'b0);
    v = adv(96'h1, 8 * 96);
    chk ("b_warm_out",   ifb.rand_out,   v);
    chk1("b_err_hold",   ifb.seed_err,   1'b1);

    // Stall: output holds
    for (int i = 0; i < 20; i++) begin
      tick();
      chk ("b_stall_out",    ifb.rand_out,   v);
      chk1("b_stall_rvalid", ifb.rand_valid, 1'b1);
    end

    // Alternating ready: advance only on accepted transfers
    for (int i = 0; i < 4; i++) begin
      ifb.rand_ready = 1'b1;
      tick();
      v = adv(v, 96);
      chk("b_alt_take", ifb.rand_out, v);
      ifb.rand_ready = 1'b0;
      tick();
      chk("b_alt_hold", ifb.rand_out, v);
    end

    // Valid reseed from RUN clears seed_err
    ifb.seed_valid = 1'b1; ifb.seed_data = s1[31:0];
    tick();
    chk1("b_rs_busy",   ifb.busy,       1'b1);
    chk1("b_rs_rvalid", ifb.rand_valid, 1'b0);
    chk ("b_rs_word0",  ifb.rand_out,   {v[95:32], s1[31:0]});
    ifb.seed_data = s1[63:32];
    tick();
    ifb.seed_data = s1[95:64];
    tick();
    ifb.seed_valid = 1'b0;
    chk1("b_rs_err_clr", ifb.seed_err, 1'b0);
    chk ("b_rs_state",   ifb.rand_out, s1);
    repeat (8) tick();
    v = adv(s1, 8 * 96);
    chk1("b_rs_rvalid2", ifb.rand_valid, 1'b1);
    chk ("b_rs_out",     ifb.rand_out,   v);

    // Reseed collides with a rand transfer: seed wins, state not drawn
    ifb.seed_valid = 1'b1; ifb.seed_data = 32'hCAFE_F00D; ifb.rand_ready = 1'b1;
    tick();
    ifb.rand_ready = 1'b0;
    chk1("b_col_rvalid", ifb.rand_valid, 1'b0);
    chk1("b_col_busy",   ifb.busy,       1'b1);
    chk ("b_col_state",  ifb.rand_out,   {v[95:32], 32'hCAFE_F00D});

    // Second word, then asynchronous reset mid-cycle discards partial seed
    ifb.seed_data = 32'h5555_AAAA;
    tick();
    ifb.seed_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk ("b_ar_out",    ifb.rand_out,   96'h0);
    chk1("b_ar_busy",   ifb.busy,       1'b0);
    chk1("b_ar_sready", ifb.seed_ready, 1'b1);
    chk1("b_ar_rvalid", ifb.rand_valid, 1'b0);
    chk1("b_ar_err",    ifb.seed_err,   1'b0);
    chk ("a_ar_out",    ifa.rand_out,   96'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh seeding reproduces the earlier stream
    ifb.seed_valid = 1'b1; ifb.seed_data = s1[31:0];
    tick();
    ifb.seed_data = s1[63:32];
    tick();
    ifb.seed_data = s1[95:64];
    tick();
    ifb.seed_valid = 1'b0;
    chk("b_re_state", ifb.rand_out, s1);
    repeat (8) tick();
    chk1("b_re_rvalid", ifb.rand_valid, 1'b1);
    chk ("b_re_out",    ifb.rand_out,   v);
    ifb.rand_ready = 1'b1;
    tick();
    ifb.rand_ready = 1'b0;
    chk("b_re_draw", ifb.rand_out, adv(v, 96));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
